mips_muldiv_seq: RTL

Parametrised multi-cycle multiply/divide unit for the integer datapath.
- Produces a full double-width product, or quotient plus remainder, on Y_hi/Y_lo, which the combinational ALU ties to zero.
- Sits beside the combinational ALU and shares its FS encoding space and flag semantics.
- Uses a start/busy/done handshake and radix-2 shift-add/restoring-division iteration, one bit per clock.

---
 rtl/mips_muldiv_seq_pkg.sv | 14 +
 rtl/mips_muldiv_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mips_muldiv_seq_pkg.sv
// rtl/mips_muldiv_seq_pkg.sv - op-select codes and FSM state encoding for the multi-cycle mul/div unit
package mips_muldiv_seq_pkg;

  localparam logic [4:0] FS_MULT  = 5'h1A;
  localparam logic [4:0] FS_MULTU = 5'h1B;
  localparam logic [4:0] FS_DIV   = 5'h1C;
  localparam logic [4:0] FS_DIVU  = 5'h1D;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - radix-2 sequential multiply/divide with start/busy/done handshake
module mips_muldiv_seq
  import mips_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             V,
  output logic             N,
  output logic             Z,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic             is_div, is_sgn, neg_lo, neg_hi, ovf;

  logic             fs_valid, op_div, op_sgn, accept;
  logic [WIDTH-1:0] s_mag, t_mag;
  logic [WIDTH:0]   mult_sum, div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, iter_hi, iter_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign fs_valid = (FS == FS_MULT) || (FS == FS_MULTU) || (FS == FS_DIV) || (FS == FS_DIVU);
  assign op_div   = (FS == FS_DIV) || (FS == FS_DIVU);
  assign op_sgn   = (FS == FS_MULT) || (FS == FS_DIV);
  assign accept   = start && fs_valid && ((state == ST_IDLE) || (state == ST_DONE));
  assign s_mag    = mag(S, op_sgn);
  assign t_mag    = mag(T, op_sgn);
  assign busy     = (state == ST_CALC) || (state == ST_FIXUP);
  assign done     = (state == ST_DONE);

  // hi/lo is the product shift pair for multiply and the remainder/quotient pair for divide
  always_comb begin
    mult_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (is_div) begin
      iter_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      iter_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mult_sum[WIDTH:1];
      iter_lo = {mult_sum[0], lo[WIDTH-1:1]};
    end
    prod_fix = neg_lo ? -{hi, lo} : {hi, lo};
    if (is_div) begin
      res_lo = neg_lo ? -lo : lo;
      res_hi = neg_hi ? -hi : hi;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      ovf    <= 1'b0;
      Y_hi   <= '0;
      Y_lo   <= '0;
      V      <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b0;
      div0   <= 1'b0;
    end else if (accept) begin
      is_div <= op_div;
      is_sgn <= op_sgn;
      neg_lo <= op_sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
      neg_hi <= op_sgn & S[WIDTH-1];
      ovf    <= op_div & op_sgn & (S == {1'b1, {(WIDTH-1){1'b0}}}) & (&T);
      hi     <= '0;
      lo     <= op_div ? s_mag : t_mag;
      opnd   <= op_div ? t_mag : s_mag;
      cnt    <= '0;
      div0   <= 1'b0;
      if (op_div && (T == '0)) begin
        Y_lo  <= '1;
        Y_hi  <= S;
        div0  <= 1'b1;
        V     <= 1'b1;
        N     <= 1'b0;
        Z     <= 1'b0;
        state <= ST_DONE;
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          hi  <= iter_hi;
          lo  <= iter_lo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          Y_hi  <= res_hi;
          Y_lo  <= res_lo;
          V     <= ovf;
          N     <= is_sgn & (is_div ? res_lo[WIDTH-1] : res_hi[WIDTH-1]);
          Z     <= is_div ? (res_lo == '0) : ({res_hi, res_lo} == '0);
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
